// File: rtl/axis_wrr_arbiter_pkg.sv
// Shared types and helpers for the three-input weighted round-robin AXIS arbiter.
// No logic: state encoding, port count and the grant rotation function.
// Imported by axis_wrr_arbiter_3 and axis_wrr_out_reg.
package axis_wrr_arbiter_pkg;

    localparam int NUM_PORTS = 3;

    // The encoding doubles as the externally visible grant index.
    typedef enum logic [1:0] {
        GRANT_0 = 2'd0,
        GRANT_1 = 2'd1,
        GRANT_2 = 2'd2
    } arb_state_t;

    // Mod-3 rotation; the unused encoding falls back to port 0.
    function automatic arb_state_t next_port(input arb_state_t cur);
        arb_state_t nxt;
        case (cur)
            GRANT_0: nxt = GRANT_1;
            GRANT_1: nxt = GRANT_2;
            default: nxt = GRANT_0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/axis_wrr_out_reg.sv
// One-entry AXIS output register shared by all arbiter inputs.
// Latency: 1 cycle from load to output_valid.
// Backpressure: can_load = !output_valid || output_ready; contents hold while stalled.
//
// Ports: clk, rst (sync, active-low), clear (sync, active-high, discards any held beat),
//        load/load_data (qualified by can_load in the parent), can_load,
//        output_valid/output_ready/output_data (AXIS master).
// Optional: AXIS_WRR_ARBITER_LAST_EN adds load_last / output_last.
module axis_wrr_out_reg
    import axis_wrr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
`ifdef AXIS_WRR_ARBITER_LAST_EN
    input  logic                  load_last,
    output logic                  output_last,
`endif
    output logic                  can_load,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [DATA_WIDTH-1:0] output_data
);

    assign can_load = !output_valid || output_ready;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            output_valid <= 1'b0;
            output_data  <= '0;
`ifdef AXIS_WRR_ARBITER_LAST_EN
            output_last  <= 1'b0;
`endif
        end else if (load) begin
            output_valid <= 1'b1;
            output_data  <= load_data;
`ifdef AXIS_WRR_ARBITER_LAST_EN
            output_last  <= load_last;
`endif
        end else if (output_ready) begin
            output_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_wrr_arbiter_3.sv
// Three-input weighted round-robin AXIS arbiter; each grant passes up to quota_i beats.
// Latency: 1 cycle input transfer to output_valid; full throughput on the granted port.
// Backpressure: granted input is readied only when the output register can load; idle ports are skipped.
//
// Ports: clk; rst (sync, active-low); clear (sync, active-high soft restart);
//        cfg_quota_0..2 (captured only during rst/clear);
//        input_0..2_valid/ready/data (AXIS slaves); output_valid/ready/data (AXIS master);
//        grant (registered index of the granted port).
// Optional: AXIS_WRR_ARBITER_LAST_EN adds input_X_last/output_last; quotas then count
//           packets and a port is never left mid-packet.
module axis_wrr_arbiter_3
    import axis_wrr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int QUOTA_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [QUOTA_WIDTH-1:0] cfg_quota_0,
    input  logic [QUOTA_WIDTH-1:0] cfg_quota_1,
    input  logic [QUOTA_WIDTH-1:0] cfg_quota_2,
    input  logic                   input_0_valid,
    output logic                   input_0_ready,
    input  logic [DATA_WIDTH-1:0]  input_0_data,
    input  logic                   input_1_valid,
    output logic                   input_1_ready,
    input  logic [DATA_WIDTH-1:0]  input_1_data,
    input  logic                   input_2_valid,
    output logic                   input_2_ready,
    input  logic [DATA_WIDTH-1:0]  input_2_data,
`ifdef AXIS_WRR_ARBITER_LAST_EN
    input  logic                   input_0_last,
    input  logic                   input_1_last,
    input  logic                   input_2_last,
    output logic                   output_last,
`endif
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [DATA_WIDTH-1:0]  output_data,
    output logic [1:0]             grant
);

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic [QUOTA_WIDTH-1:0] count;
    logic [QUOTA_WIDTH-1:0] count_nxt;
    logic [QUOTA_WIDTH-1:0] quota_0;
    logic [QUOTA_WIDTH-1:0] quota_1;
    logic [QUOTA_WIDTH-1:0] quota_2;
    logic [QUOTA_WIDTH-1:0] sel_quota;
    logic                   sel_valid;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   can_load;
    logic                   run_ok;
    logic                   xfer;
    logic [QUOTA_WIDTH:0]   count_inc;
    logic                   quota_hit;
`ifdef AXIS_WRR_ARBITER_LAST_EN
    logic                   sel_last;
    logic                   in_pkt;
    logic                   in_pkt_nxt;
`endif

    // Quotas are only sampled while held in reset/clear so a live reconfigure
    // cannot change a burst length mid-rotation.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            quota_0 <= cfg_quota_0;
            quota_1 <= cfg_quota_1;
            quota_2 <= cfg_quota_2;
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_quota = '0;
`ifdef AXIS_WRR_ARBITER_LAST_EN
        sel_last  = 1'b0;
`endif
        case (state)
            GRANT_0: begin
                sel_valid = input_0_valid;
                sel_data  = input_0_data;
                sel_quota = quota_0;
`ifdef AXIS_WRR_ARBITER_LAST_EN
                sel_last  = input_0_last;
`endif
            end
            GRANT_1: begin
                sel_valid = input_1_valid;
                sel_data  = input_1_data;
                sel_quota = quota_1;
`ifdef AXIS_WRR_ARBITER_LAST_EN
                sel_last  = input_1_last;
`endif
            end
            GRANT_2: begin
                sel_valid = input_2_valid;
                sel_data  = input_2_data;
                sel_quota = quota_2;
`ifdef AXIS_WRR_ARBITER_LAST_EN
                sel_last  = input_2_last;
`endif
            end
            default: ;
        endcase
    end

    // Ready never looks at valid. A zero-quota port is never readied: its
    // grant cycle is a pure skip.
    assign run_ok        = rst && !clear && can_load && (sel_quota != '0);
    assign input_0_ready = run_ok && (state == GRANT_0);
    assign input_1_ready = run_ok && (state == GRANT_1);
    assign input_2_ready = run_ok && (state == GRANT_2);
    assign xfer          = sel_valid && run_ok;

    // One extra bit so a quota of 2^QUOTA_WIDTH-1 compares without wrap.
    assign count_inc = {1'b0, count} + {{QUOTA_WIDTH{1'b0}}, 1'b1};
    assign quota_hit = (count_inc == {1'b0, sel_quota});

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
`ifdef AXIS_WRR_ARBITER_LAST_EN
        in_pkt_nxt = in_pkt;
        if (sel_quota == '0) begin
            state_nxt = next_port(state);
            count_nxt = '0;
        end else if (xfer) begin
            if (sel_last) begin
                in_pkt_nxt = 1'b0;
                if (quota_hit) begin
                    state_nxt = next_port(state);
                    count_nxt = '0;
                end else begin
                    count_nxt = count_inc[QUOTA_WIDTH-1:0];
                end
            end else begin
                in_pkt_nxt = 1'b1;
            end
        end else if (!sel_valid && !in_pkt) begin
            // Idle skip only at a packet boundary; mid-packet gaps hold the grant.
            state_nxt = next_port(state);
            count_nxt = '0;
        end
`else
        if (sel_quota == '0) begin
            state_nxt = next_port(state);
            count_nxt = '0;
        end else if (xfer) begin
            if (quota_hit) begin
                state_nxt = next_port(state);
                count_nxt = '0;
            end else begin
                count_nxt = count_inc[QUOTA_WIDTH-1:0];
            end
        end else if (!sel_valid) begin
            state_nxt = next_port(state);
            count_nxt = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            state  <= GRANT_0;
            count  <= '0;
`ifdef AXIS_WRR_ARBITER_LAST_EN
            in_pkt <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
`ifdef AXIS_WRR_ARBITER_LAST_EN
            in_pkt <= in_pkt_nxt;
`endif
        end
    end

    assign grant = state;

    axis_wrr_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .load         (xfer),
        .load_data    (sel_data),
`ifdef AXIS_WRR_ARBITER_LAST_EN
        .load_last    (sel_last),
        .output_last  (output_last),
`endif
        .can_load     (can_load),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data)
    );

endmodule

// File: tb/tb_axis_wrr_arbiter_3.sv
// Testbench for axis_wrr_arbiter_3: producers stream p*256+n, a scoreboard predicts
// the output order from the quota rotation rules, and per-grant burst lengths,
// stall stability, reset/clear state and (optionally) packet framing are checked.
module tb_axis_wrr_arbiter_3;

    localparam int DW = 16;
    localparam int QW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic [QW-1:0] cfg_q [3];
    logic [2:0]    in_valid;
    logic [DW-1:0] in_data [3];
    logic [2:0]    in_last;
    logic          rdy_0, rdy_1, rdy_2;
    logic [2:0]    in_ready;
    logic          output_valid;
    logic          output_ready;
    logic [DW-1:0] output_data;
    logic [1:0]    grant;
    logic          out_last_w;

    assign in_ready = {rdy_2, rdy_1, rdy_0};

    always #5 clk = ~clk;

`ifdef AXIS_WRR_ARBITER_LAST_EN
    logic output_last;
    assign out_last_w = output_last;
`else
    assign out_last_w = 1'b1;
`endif

    axis_wrr_arbiter_3 #(.DATA_WIDTH(DW), .QUOTA_WIDTH(QW)) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .cfg_quota_0   (cfg_q[0]),
        .cfg_quota_1   (cfg_q[1]),
        .cfg_quota_2   (cfg_q[2]),
        .input_0_valid (in_valid[0]),
        .input_0_ready (rdy_0),
        .input_0_data  (in_data[0]),
        .input_1_valid (in_valid[1]),
        .input_1_ready (rdy_1),
        .input_1_data  (in_data[1]),
        .input_2_valid (in_valid[2]),
        .input_2_ready (rdy_2),
        .input_2_data  (in_data[2]),
`ifdef AXIS_WRR_ARBITER_LAST_EN
        .input_0_last  (in_last[0]),
        .input_1_last  (in_last[1]),
        .input_2_last  (in_last[2]),
        .output_last   (output_last),
`endif
        .output_valid  (output_valid),
        .output_ready  (output_ready),
        .output_data   (output_data),
        .grant         (grant)
    );

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [QW-1:0] q_m [3];
    logic [2:0]    act_m;
    int            ready_mode;
    int            sent [3];
    bit            pend [3];
    logic [DW:0]   cap_q [$];
    logic [DW:0]   exp_q [$];
    bit            ep_chk_en;
    bit            prev_stall;
    logic [DW:0]   prev_beat;
    int            cur_grant;
    int            ep_cnt;
    int            cyc;
    int            first_in;
    int            first_out;
    int            rdy_bad;
    int            zq_rdy;
    int            ovalid_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nextp(input int g);
        return (g + 1) % 3;
    endfunction

    function automatic int exp_burst(input int p);
        return (act_m[p] && q_m[p] != 0) ? int'(q_m[p]) : 0;
    endfunction

    // Called at the falling edge: everything seen here takes effect on the next rising edge.
    task automatic sample();
        logic [DW:0] beat;
        beat = {out_last_w, output_data};
        cyc++;
        if (prev_stall) chk("stall_hold", {15'd0, output_valid, beat}, {15'd0, 1'b1, prev_beat});
        prev_stall = output_valid && !output_ready;
        prev_beat  = beat;
        if (output_valid) begin
            ovalid_cycles++;
            if (first_out < 0) first_out = cyc;
        end
        if (output_valid && output_ready) cap_q.push_back(beat);
        if (ep_chk_en && int'(grant) != cur_grant) begin
            chk("grant_next", 32'(grant), 32'(nextp(cur_grant)));
            chk("burst_len", 32'(ep_cnt), 32'(exp_burst(cur_grant)));
            cur_grant = int'(grant);
            ep_cnt    = 0;
        end
        for (int p = 0; p < 3; p++) begin
            pend[p] = in_valid[p] && in_ready[p];
            if (in_ready[p] && int'(grant) != p) rdy_bad++;
            if (in_ready[p] && q_m[p] == 0) zq_rdy++;
            if (pend[p]) begin
                ep_cnt++;
                if (first_in < 0) first_in = cyc;
            end
        end
    endtask

    task automatic drive();
        for (int p = 0; p < 3; p++) begin
            if (pend[p]) begin
                sent[p]++;
                in_data[p] = 16'(p * 256 + sent[p]);
            end
            pend[p] = 1'b0;
        end
        case (ready_mode)
            0:       output_ready = 1'b1;
            1:       output_ready = ~output_ready;
            default: output_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        drive();
    endtask

    // Holds rst low or clear high for two cycles, checks the idle state, then
    // releases with scrambled cfg inputs so only the captured quotas matter.
    task automatic restart(input bit use_clear, input logic [QW-1:0] a, input logic [QW-1:0] b,
                           input logic [QW-1:0] c);
        cfg_q[0] = a; cfg_q[1] = b; cfg_q[2] = c;
        q_m[0]   = a; q_m[1]   = b; q_m[2]   = c;
        if (use_clear) clear = 1'b1;
        else           rst   = 1'b0;
        @(negedge clk);
        chk("rst_ready_c1", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ovalid", 32'(output_valid), 32'd0);
        chk("rst_odata", 32'(output_data), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ready_c2", 32'(in_ready), 32'd0);
`ifdef AXIS_WRR_ARBITER_LAST_EN
        chk("rst_olast", 32'(output_last), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst   = 1'b1;
        clear = 1'b0;
        for (int p = 0; p < 3; p++) begin
            cfg_q[p]   = QW'($urandom);
            sent[p]    = 0;
            pend[p]    = 1'b0;
            in_data[p] = 16'(p * 256);
        end
        cap_q.delete();
        output_ready  = 1'b1;
        prev_stall    = 1'b0;
        cur_grant     = 0;
        ep_cnt        = 0;
        cyc           = 0;
        first_in      = -1;
        first_out     = -1;
        rdy_bad       = 0;
        zq_rdy        = 0;
        ovalid_cycles = 0;
    endtask

    // Reference order: visit ports 0,1,2 repeatedly; every active port with a
    // non-zero quota contributes exactly quota beats of its own count sequence.
    task automatic check_phase(input int min_beats);
        int idx [3];
        bit any;
        idx = '{0, 0, 0};
        any = 1'b0;
        exp_q.delete();
        for (int p = 0; p < 3; p++) if (act_m[p] && q_m[p] != 0) any = 1'b1;
        if (any) begin
            while (exp_q.size() < cap_q.size()) begin
                for (int p = 0; p < 3; p++) begin
                    if (act_m[p] && q_m[p] != 0) begin
                        for (int k = 0; k < int'(q_m[p]); k++) begin
                            exp_q.push_back({1'b1, 16'(p * 256 + idx[p])});
                            idx[p]++;
                        end
                    end
                end
            end
            chk("progress", 32'(cap_q.size() >= min_beats), 32'd1);
            for (int k = 0; k < cap_q.size(); k++)
                chk($sformatf("beat%0d", k), 32'(cap_q[k]), 32'(exp_q[k]));
        end else begin
            chk("no_output", 32'(cap_q.size()), 32'd0);
            chk("ovalid_never", 32'(ovalid_cycles), 32'd0);
        end
        chk("ready_wrong_port", 32'(rdy_bad), 32'd0);
        chk("ready_zero_quota", 32'(zq_rdy), 32'd0);
    endtask

    task automatic setup(input logic [2:0] act, input int mode);
        act_m      = act;
        in_valid   = act;
        ready_mode = mode;
        ep_chk_en  = 1'b1;
    endtask

`ifdef AXIS_WRR_ARBITER_LAST_EN
    task automatic last_test();
        int i0, i1;
        bit gap_done;
        logic [DW:0] exp_l [5];
        exp_l = '{17'h0_00A0, 17'h0_00A1, 17'h1_00A2, 17'h0_01B0, 17'h1_01B1};
        setup(3'b000, 0);
        ep_chk_en = 1'b0;
        restart(1'b0, 8'd1, 8'd1, 8'd1);
        i0 = 0; i1 = 0; gap_done = 1'b0;
        repeat (30) begin
            in_valid[0] = (i0 < 3) && !(i0 == 1 && !gap_done);
            in_data[0]  = 16'(16'h00A0 + i0);
            in_last[0]  = (i0 == 2);
            in_valid[1] = (i1 < 2);
            in_data[1]  = 16'(16'h01B0 + i1);
            in_last[1]  = (i1 == 1);
            in_valid[2] = 1'b0;
            @(negedge clk);
            sample();
            if (i0 == 1 && !gap_done) begin
                chk("gap_hold_grant", 32'(grant), 32'd0);
                gap_done = 1'b1;
            end
            if (pend[0]) i0++;
            if (pend[1]) i1++;
            @(posedge clk);
            #1;
        end
        chk("pkt_beats", 32'(cap_q.size()), 32'd5);
        for (int k = 0; k < 5 && k < cap_q.size(); k++)
            chk($sformatf("pkt_beat%0d", k), 32'(cap_q[k]), 32'(exp_l[k]));
        in_last  = 3'b111;
        in_valid = 3'b000;
    endtask
`endif

    initial begin
        rst          = 1'b0;
        clear        = 1'b0;
        in_valid     = 3'b000;
        in_last      = 3'b111;
        output_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            cfg_q[p]   = '0;
            in_data[p] = '0;
        end

        // Quotas 2/3/1, everything valid, drain always ready.
        setup(3'b111, 0);
        restart(1'b0, 8'd2, 8'd3, 8'd1);
        repeat (60) step();
        chk("first_in_cycle", 32'(first_in), 32'd1);
        chk("latency", 32'(first_out - first_in), 32'd1);
        chk("throughput", 32'(ovalid_cycles), 32'd59);
        check_phase(55);

        // Only port 1 valid: idle ports cost one skip cycle each.
        setup(3'b010, 0);
        restart(1'b0, 8'd4, 8'd4, 8'd4);
        repeat (60) step();
        check_phase(30);

        // Drain toggling every cycle.
        setup(3'b111, 1);
        restart(1'b1, 8'd3, 8'd3, 8'd3);
        repeat (80) step();
        check_phase(30);

        // Zero quotas on ports 0 and 2.
        setup(3'b111, 0);
        restart(1'b0, 8'd0, 8'd5, 8'd0);
        repeat (60) step();
        check_phase(30);

        // Soft restart mid-burst, then the same through rst.
        for (int kind = 1; kind >= 0; kind--) begin
            setup(3'b111, 0);
            restart(1'b0, 8'd2, 8'd3, 8'd1);
            repeat (3) step();
            chk("mid_burst_grant", 32'(grant), 32'd1);
            check_phase(2);
            restart(kind[0], 8'd1, 8'd1, 8'd1);
            repeat (30) step();
            check_phase(25);
        end

        // Maximum quota on port 0.
        setup(3'b011, 0);
        restart(1'b0, 8'd255, 8'd2, 8'd0);
        repeat (300) step();
        check_phase(250);

        // All quotas zero: rotation only, nothing ever moves.
        setup(3'b111, 0);
        restart(1'b1, 8'd0, 8'd0, 8'd0);
        repeat (20) step();
        check_phase(0);

        // Randomised quotas, activity masks and drain backpressure.
        for (int it = 0; it < 8; it++) begin
            setup(3'($urandom_range(0, 7)), 2);
            restart(1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)),
                    8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)));
            repeat (150) step();
            check_phase(9);
        end

`ifdef AXIS_WRR_ARBITER_LAST_EN
        last_test();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_wrr_arbiter_3.md
Name: axis_wrr_arbiter_3

Overview:
- Three-input, one-output AXI-Stream weighted round-robin arbiter.
- It shares one downstream consumer between three stream producers, for example the inputs feeding a merge stage.
- Each port receives a burst of up to a programmable number of beats, and then the grant rotates.
- Idle ports are skipped, so the block is work-conserving; the output is registered.

Parameters:
- DATA_WIDTH, 16, width of every data bus.
- QUOTA_WIDTH, 8, width of each per-port quota and of the beat counter.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-low reset.
- clear  in  1  synchronous soft restart, active-high.
- cfg_quota_0  in  QUOTA_WIDTH  beats per grant for port 0; latched only in reset or clear.
- cfg_quota_1  in  QUOTA_WIDTH  beats per grant for port 1; latched only in reset or clear.
- cfg_quota_2  in  QUOTA_WIDTH  beats per grant for port 2; latched only in reset or clear.
- input_0_valid / input_0_ready / input_0_data  in / out / in  1 / 1 / DATA_WIDTH  AXIS slave 0.
- input_1_valid / input_1_ready / input_1_data  in / out / in  1 / 1 / DATA_WIDTH  AXIS slave 1.
- input_2_valid / input_2_ready / input_2_data  in / out / in  1 / 1 / DATA_WIDTH  AXIS slave 2.
- output_valid  out  1  AXIS master valid.
- output_ready  in  1  AXIS master ready.
- output_data  out  DATA_WIDTH  AXIS master data.
- grant  out  2  index of the currently granted port (0..2), for debug and monitoring.

Behaviour:
- Reset, when rst=0 at a clock edge:
  - state=GRANT_0, beat count=0.
  - output_valid=0, output_data=0, grant=0, all input_X_ready=0.
  - Quota registers load from cfg_quota_X.
- clear=1 has the same effect as reset.
  - Any beat held in the output register is discarded.
  - Clear takes priority over any transfer in the same cycle.
- Output stage is a one-entry register.
  - can_load = !output_valid || output_ready.
  - input_i_ready = (state==GRANT_i) && can_load && rst && !clear; ungranted ports see ready=0.
  - A transfer on port i (valid&&ready) loads output_data and sets output_valid=1 on the next edge.
  - output_valid clears when output_ready=1 and no new load occurs.
  - Latency is 1 cycle from input transfer to output_valid.
  - Full throughput: one beat per cycle while the granted port and downstream are both ready.
- Output data and valid are stable while output_valid=1 and output_ready=0.
- FSM states are GRANT_0, GRANT_1, GRANT_2; "next" means (i+1) mod 3.
- In GRANT_i:
  - If quota_i==0: go to next state on the next edge, count=0, no transfer.
  - Else if a transfer occurs and count+1==quota_i: go to next state, count=0.
  - Else if a transfer occurs: count=count+1 and stay.
  - Else if input_i_valid==0: go to next state, count=0 (idle skip, one cycle per skipped port).
  - Else (valid but backpressured, can_load=0): stay and hold count.
- All quotas zero: the FSM rotates continuously, no input is ever readied, and output_valid stays 0.
- Count arithmetic is unsigned QUOTA_WIDTH bits.
  - The maximum quota is 2^QUOTA_WIDTH-1.
  - The comparison count+1==quota is done in QUOTA_WIDTH+1 bits, so count never wraps.
- grant equals the state encoding and is registered.
- Inputs must not be readied combinationally from their own valid; ready depends only on state, output register, rst and clear.

Optional Feature:
- Macro: AXIS_WRR_ARBITER_LAST_EN.
- When defined:
  - Adds input_0_last, input_1_last, input_2_last (in, 1 each) and output_last (out, 1), registered alongside data.
  - Quotas count packets, i.e. transfers with last=1, instead of beats.
  - The idle skip is taken only at packet boundaries: no beat of the current packet accepted yet.
  - Mid-packet, the FSM holds GRANT_i while valid=0, so packets are never interleaved.
  - output_last resets to 0.
- When undefined: no last ports, and arbitration is beat-based as described above.

Decomposition:
- Package axis_wrr_arbiter_pkg holds:
  - typedef enum logic [1:0] {GRANT_0, GRANT_1, GRANT_2} arb_state_t;
  - localparam NUM_PORTS = 3.
  - A next_port() function implementing mod-3 increment.
- Sub-module axis_wrr_out_reg: the one-entry output register with the can_load handshake, parameterised by DATA_WIDTH (plus the last bit under the macro).
- The FSM and counter stay in the top module.

Test Plan:
- Quotas 2/3/1, all inputs always valid with incrementing data (port p sends p*256+n), drain always ready:
  - Output order is 0,0,1,1,1,2 repeating at 1 beat/cycle.
  - First output_valid appears 1 cycle after the first input transfer.
- Quotas 4/4/4, only port 1 valid: after one skip cycle per idle port, port 1 sends 4 beats per rotation, and grant cycles 0→1→2→0.
- Quotas 3/3/3, all valid, drain ready toggling 1/0 every cycle:
  - No data lost or duplicated.
  - output_data is held across stall cycles.
  - Each port still receives exactly 3 beats per grant.
- Quotas 0/5/0: port 0 and port 2 ready never asserts, and all output comes from port 1 in bursts of 5.
- Assert clear for 2 cycles mid-burst (port 1, count=1), with cfg changed to 1/1/1 during clear:
  - output_valid=0 during clear.
  - The first beat after clear comes from port 0, and the rotation is 0,1,2 single beats.
  - Repeat with rst=0 for the same result.
- With AXIS_WRR_ARBITER_LAST_EN, quotas 1/1/1, port 0 sends a 3-beat packet with a valid gap after beat 1:
  - Grant holds on port 0 through the gap.
  - output_last=1 only on beat 3.
  - Port 1's packet follows without interleaving.
